// File: rtl/dma_fifo_pkg.sv
// Shared definitions for the DMA stream FIFO: read-mode codes, count-width helper
// and the packed status bus that channel arbiters sample.
package dma_fifo_pkg;

   localparam int FIFO_MODE_REG  = 0;
   localparam int FIFO_MODE_FWFT = 1;

   function automatic int fifo_cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
      logic overflow;
      logic underflow;
   } fifo_status_t;

endpackage

// File: rtl/dma_fifo_mem.sv
// Plain register-array storage for dma_stream_fifo: one synchronous write port and an
// asynchronous read address, kept separate so it can be replaced by an SRAM macro.
module dma_fifo_mem #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   // Storage is intentionally not reset; occupancy is tracked by the controller.
   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dma_stream_fifo.sv
// Parametrised DMA data-path FIFO with registered or fall-through read, watermarks,
// occupancy count, flush and sticky overflow/underflow. Optional macro: DMA_FIFO_PARITY_EN.
module dma_stream_fifo
   import dma_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 16,
   parameter int FWFT       = FIFO_MODE_REG,
   parameter int AF_LEVEL   = FIFO_DEPTH - 2,
   parameter int AE_LEVEL   = 2
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                flush,
   input  logic                                wr_en,
   input  logic [DATA_WIDTH-1:0]               wdata,
   input  logic                                rd_en,
   output logic [DATA_WIDTH-1:0]               rdata,
   output logic                                rvalid,
   output logic                                full,
   output logic                                empty,
   output logic                                almost_full,
   output logic                                almost_empty,
   output logic [fifo_cnt_w(FIFO_DEPTH)-1:0]   count,
   output logic                                overflow,
   output logic                                underflow
`ifdef DMA_FIFO_PARITY_EN
   ,
   output logic                                parity_err
`endif
);

   localparam int CW = fifo_cnt_w(FIFO_DEPTH);
   localparam int PW = $clog2(FIFO_DEPTH);
`ifdef DMA_FIFO_PARITY_EN
   localparam int MW = DATA_WIDTH + 1;
`else
   localparam int MW = DATA_WIDTH;
`endif

   if (FIFO_DEPTH < 2) begin : g_chk_depth
      $fatal(1, "dma_stream_fifo: FIFO_DEPTH must be >= 2");
   end
   if (AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > FIFO_DEPTH) begin : g_chk_levels
      $fatal(1, "dma_stream_fifo: need 0 <= AE_LEVEL < AF_LEVEL <= FIFO_DEPTH");
   end
   if (FWFT != FIFO_MODE_REG && FWFT != FIFO_MODE_FWFT) begin : g_chk_mode
      $fatal(1, "dma_stream_fifo: FWFT must be 0 or 1");
   end

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          udf_q, udf_d;
   logic          wr_acc, rd_acc;
   fifo_status_t  status;
   logic [MW-1:0] mem_wdata, mem_rdata;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      status              = '0;
      status.full         = (count_q == CW'(FIFO_DEPTH));
      status.empty        = (count_q == '0);
      status.almost_full  = (count_q >= CW'(AF_LEVEL));
      status.almost_empty = (count_q <= CW'(AE_LEVEL));
      status.overflow     = ovf_q;
      status.underflow    = udf_q;
   end

   assign wr_acc = wr_en & ~status.full;
   assign rd_acc = rd_en & ~status.empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      udf_d    = udf_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
         udf_d    = 1'b0;
      end else begin
         if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (rd_acc) rd_ptr_d = ptr_inc(rd_ptr_q);
         case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
         ovf_d = ovf_q | (wr_en & status.full);
         udf_d = udf_q | (rd_en & status.empty);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

`ifdef DMA_FIFO_PARITY_EN
   assign mem_wdata = {^wdata, wdata};
`else
   assign mem_wdata = wdata;
`endif

   dma_fifo_mem #(
      .WIDTH (MW),
      .DEPTH (FIFO_DEPTH),
      .AW    (PW)
   ) u_mem (
      .clk     (clk),
      .we_i    (wr_acc & ~flush),
      .waddr_i (wr_ptr_q),
      .wdata_i (mem_wdata),
      .raddr_i (rd_ptr_q),
      .rdata_o (mem_rdata)
   );

   // Handshake: rd_en is a pop request honoured only when not empty; rvalid qualifies
   // rdata (next cycle in registered mode, same cycle as the visible head in FWFT mode).
   if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      assign rdata  = mem_rdata[DATA_WIDTH-1:0];
      assign rvalid = ~status.empty;
`ifdef DMA_FIFO_PARITY_EN
      assign parity_err = rd_acc & (^mem_rdata);
`endif
   end else begin : g_reg
      logic [DATA_WIDTH-1:0] rdata_q;
      logic                  rvalid_q;
`ifdef DMA_FIFO_PARITY_EN
      logic                  perr_q;
`endif
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
`ifdef DMA_FIFO_PARITY_EN
            perr_q   <= 1'b0;
`endif
         end else if (flush) begin
            rvalid_q <= 1'b0;
`ifdef DMA_FIFO_PARITY_EN
            perr_q   <= 1'b0;
`endif
         end else begin
            rvalid_q <= rd_acc;
            if (rd_acc) rdata_q <= mem_rdata[DATA_WIDTH-1:0];
`ifdef DMA_FIFO_PARITY_EN
            perr_q   <= rd_acc & (^mem_rdata);
`endif
         end
      end
      assign rdata  = rdata_q;
      assign rvalid = rvalid_q;
`ifdef DMA_FIFO_PARITY_EN
      assign parity_err = perr_q;
`endif
   end

   assign full         = status.full;
   assign empty        = status.empty;
   assign almost_full  = status.almost_full;
   assign almost_empty = status.almost_empty;
   assign overflow     = status.overflow;
   assign underflow    = status.underflow;
   assign count        = count_q;

endmodule

// File: tb/tb_dma_stream_fifo.sv
// Bench for dma_stream_fifo: 16-deep registered, 5-deep registered (table driven)
// and 16-deep fall-through instances sharing one clock and reset.
module tb_dma_stream_fifo;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- instance A: depth 16, registered read ----------------
   logic        a_wr, a_rd, a_flush;
   logic [31:0] a_wd, a_rdata;
   logic        a_rvalid, a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
   logic [4:0]  a_cnt;
   logic [31:0] a_exp_q[$];
   int          a_mcnt;
   int          a_rv_cnt;
`ifdef DMA_FIFO_PARITY_EN
   logic        a_perr, b_perr, c_perr;
`endif

   dma_stream_fifo #(.DATA_WIDTH(32), .FIFO_DEPTH(16), .FWFT(0), .AF_LEVEL(14), .AE_LEVEL(2)) dut_a (
      .clk(clk), .rst(rst_n), .flush(a_flush), .wr_en(a_wr), .wdata(a_wd), .rd_en(a_rd),
      .rdata(a_rdata), .rvalid(a_rvalid), .full(a_full), .empty(a_empty),
      .almost_full(a_af), .almost_empty(a_ae), .count(a_cnt), .overflow(a_ovf), .underflow(a_udf)
`ifdef DMA_FIFO_PARITY_EN
      , .parity_err(a_perr)
`endif
   );

   // ---------------- instance B: depth 5, registered read ----------------
   logic        b_wr, b_rd, b_flush;
   logic [31:0] b_wd, b_rdata;
   logic        b_rvalid, b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
   logic [2:0]  b_cnt;
   logic [31:0] b_exp_q[$];
   int          b_mcnt;

   dma_stream_fifo #(.DATA_WIDTH(32), .FIFO_DEPTH(5), .FWFT(0)) dut_b (
      .clk(clk), .rst(rst_n), .flush(b_flush), .wr_en(b_wr), .wdata(b_wd), .rd_en(b_rd),
      .rdata(b_rdata), .rvalid(b_rvalid), .full(b_full), .empty(b_empty),
      .almost_full(b_af), .almost_empty(b_ae), .count(b_cnt), .overflow(b_ovf), .underflow(b_udf)
`ifdef DMA_FIFO_PARITY_EN
      , .parity_err(b_perr)
`endif
   );

   // ---------------- instance C: depth 16, first-word fall-through ----------------
   logic        c_wr, c_rd, c_flush;
   logic [31:0] c_wd, c_rdata;
   logic        c_rvalid, c_full, c_empty, c_af, c_ae, c_ovf, c_udf;
   logic [4:0]  c_cnt;

   dma_stream_fifo #(.DATA_WIDTH(32), .FIFO_DEPTH(16), .FWFT(1)) dut_c (
      .clk(clk), .rst(rst_n), .flush(c_flush), .wr_en(c_wr), .wdata(c_wd), .rd_en(c_rd),
      .rdata(c_rdata), .rvalid(c_rvalid), .full(c_full), .empty(c_empty),
      .almost_full(c_af), .almost_empty(c_ae), .count(c_cnt), .overflow(c_ovf), .underflow(c_udf)
`ifdef DMA_FIFO_PARITY_EN
      , .parity_err(c_perr)
`endif
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   // ---------------- driver tasks (one clock per call) ----------------
   task automatic cyc_a(input logic wr, input logic rd, input logic fl, input logic [31:0] wd);
      logic wacc, racc;
      a_wr = wr; a_rd = rd; a_flush = fl; a_wd = wd;
      wacc = wr && !fl && (a_mcnt < 16);
      racc = rd && !fl && (a_mcnt > 0);
      @(posedge clk);
      if (fl) begin
         a_exp_q.delete();
         a_mcnt = 0;
      end else begin
         if (wacc) a_exp_q.push_back(wd);
         a_mcnt = a_mcnt + int'(wacc) - int'(racc);
      end
      #1;
      a_wr = 1'b0; a_rd = 1'b0; a_flush = 1'b0;
   endtask

   task automatic cyc_b(input logic wr, input logic rd, input logic fl, input logic [31:0] wd);
      logic wacc, racc;
      b_wr = wr; b_rd = rd; b_flush = fl; b_wd = wd;
      wacc = wr && !fl && (b_mcnt < 5);
      racc = rd && !fl && (b_mcnt > 0);
      @(posedge clk);
      if (fl) begin
         b_exp_q.delete();
         b_mcnt = 0;
      end else begin
         if (wacc) b_exp_q.push_back(wd);
         b_mcnt = b_mcnt + int'(wacc) - int'(racc);
      end
      #1;
      b_wr = 1'b0; b_rd = 1'b0; b_flush = 1'b0;
   endtask

   task automatic cyc_c(input logic wr, input logic rd, input logic fl, input logic [31:0] wd);
      c_wr = wr; c_rd = rd; c_flush = fl; c_wd = wd;
      @(posedge clk);
      #1;
      c_wr = 1'b0; c_rd = 1'b0; c_flush = 1'b0;
   endtask

   // ---------------- scoreboard monitors (sample on falling edge) ----------------
   always @(negedge clk) begin
      if (a_rvalid) begin
         a_rv_cnt++;
         if (a_exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL a_unexpected_rvalid actual=0x%0h required=no_data", a_rdata);
         end else begin
            chk("a_rdata", a_rdata, a_exp_q.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (b_rvalid) begin
         if (b_exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL b_unexpected_rvalid actual=0x%0h required=no_data", b_rdata);
         end else begin
            chk("b_rdata", b_rdata, b_exp_q.pop_front());
         end
      end
   end

   // ---------------- stimulus table for instance B ----------------
   typedef struct {
      logic        wr;
      logic        rd;
      logic        fl;
      logic [31:0] wd;
      logic [2:0]  cnt;
      logic [5:0]  flg;  // {full, empty, almost_full, almost_empty, overflow, underflow}
   } vec_t;

   vec_t tbl[16];

   initial begin
      checks = 0; failures = 0;
      a_wr = 0; a_rd = 0; a_flush = 0; a_wd = '0; a_mcnt = 0; a_rv_cnt = 0;
      b_wr = 0; b_rd = 0; b_flush = 0; b_wd = '0; b_mcnt = 0;
      c_wr = 0; c_rd = 0; c_flush = 0; c_wd = '0;

      tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h11, 3'd1, 6'b000100};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h12, 3'd2, 6'b000100};
      tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h13, 3'd3, 6'b001000};
      tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h14, 3'd4, 6'b001000};
      tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h15, 3'd5, 6'b101000};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h16, 3'd5, 6'b101010};
      tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'h17, 3'd4, 6'b001010};
      tbl[7]  = '{1'b0, 1'b1, 1'b0, 32'h00, 3'd3, 6'b001010};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'h00, 3'd2, 6'b000110};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'h00, 3'd1, 6'b000110};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h00, 3'd0, 6'b010110};
      tbl[11] = '{1'b0, 1'b1, 1'b0, 32'h00, 3'd0, 6'b010111};
      tbl[12] = '{1'b1, 1'b1, 1'b0, 32'h18, 3'd1, 6'b000111};
      tbl[13] = '{1'b1, 1'b0, 1'b1, 32'h19, 3'd0, 6'b010100};
      tbl[14] = '{1'b0, 1'b1, 1'b0, 32'h00, 3'd0, 6'b010101};
      tbl[15] = '{1'b0, 1'b0, 1'b1, 32'h00, 3'd0, 6'b010100};

      // ---- reset values (async, before any clock edge is released) ----
      rst_n = 1'b0;
      #12;
      chk("rst_a_count", 32'(a_cnt), 32'd0);
      chk("rst_a_rdata", a_rdata, 32'd0);
      chk("rst_a_flags", {26'd0, a_full, a_empty, a_af, a_ae, a_ovf, a_udf}, 32'b010100);
      chk("rst_a_rvalid", 32'(a_rvalid), 32'd0);
      chk("rst_c_rvalid", 32'(c_rvalid), 32'd0);
      #10;
      rst_n = 1'b1;

      // ---- B: table-driven flags, overflow/underflow and flush ----
      for (int i = 0; i < 16; i++) begin
         cyc_b(tbl[i].wr, tbl[i].rd, tbl[i].fl, tbl[i].wd);
         chk($sformatf("b_tbl%0d_count", i), 32'(b_cnt), 32'(tbl[i].cnt));
         chk($sformatf("b_tbl%0d_flags", i), {26'd0, b_full, b_empty, b_af, b_ae, b_ovf, b_udf},
             32'(tbl[i].flg));
      end
      chk("b_tbl_drained", b_exp_q.size(), 32'd0);

      // ---- B: three rounds of 4 words, pointers wrap past entry 4 ----
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 4; k++) begin
            cyc_b(1'b1, 1'b0, 1'b0, 32'h40 + 32'(r * 16 + k) + $urandom_range(0, 3) * 32'h1000);
            chk("b_round_count_max", 32'(b_cnt <= 3'd5), 32'd1);
         end
         for (int k = 0; k < 4; k++) cyc_b(1'b0, 1'b1, 1'b0, 32'h0);
      end
      cyc_b(1'b0, 1'b0, 1'b0, 32'h0);
      chk("b_rounds_drained", b_exp_q.size(), 32'd0);
      chk("b_rounds_empty", 32'(b_empty), 32'd1);

      // ---- C: first-word fall-through ----
      cyc_c(1'b1, 1'b0, 1'b0, 32'hA5A5A5A5);
      chk("c_fwft_rvalid", 32'(c_rvalid), 32'd1);
      chk("c_fwft_rdata", c_rdata, 32'hA5A5A5A5);
      cyc_c(1'b0, 1'b0, 1'b0, 32'h0);
      chk("c_fwft_hold", c_rdata, 32'hA5A5A5A5);
      cyc_c(1'b0, 1'b1, 1'b0, 32'h0);
      chk("c_pop_rvalid", 32'(c_rvalid), 32'd0);
      chk("c_pop_count", 32'(c_cnt), 32'd0);
      cyc_c(1'b1, 1'b1, 1'b0, 32'h5A5A0001);
      chk("c_empty_wrrd_count", 32'(c_cnt), 32'd1);
      chk("c_empty_wrrd_udf", 32'(c_udf), 32'd1);
      chk("c_empty_wrrd_rdata", c_rdata, 32'h5A5A0001);
      cyc_c(1'b1, 1'b0, 1'b0, 32'h5A5A0002);
      cyc_c(1'b1, 1'b1, 1'b0, 32'h5A5A0003);
      chk("c_wrrd_count", 32'(c_cnt), 32'd2);
      chk("c_wrrd_head", c_rdata, 32'h5A5A0002);
      cyc_c(1'b0, 1'b0, 1'b1, 32'h0);
      chk("c_flush_rvalid", 32'(c_rvalid), 32'd0);
      chk("c_flush_udf", 32'(c_udf), 32'd0);

      // ---- A: fill 16, watermarks ----
      a_rv_cnt = 0;
      for (int i = 1; i <= 16; i++) begin
         cyc_a(1'b1, 1'b0, 1'b0, 32'(i));
         chk("a_fill_count", 32'(a_cnt), 32'(i));
         chk("a_fill_af", 32'(a_af), 32'(i >= 14));
         chk("a_fill_ae", 32'(a_ae), 32'(i <= 2));
         chk("a_fill_full", 32'(a_full), 32'(i == 16));
      end
      cyc_a(1'b1, 1'b0, 1'b0, 32'hDEAD);
      chk("a_ovf_count", 32'(a_cnt), 32'd16);
      chk("a_ovf_flag", 32'(a_ovf), 32'd1);
      cyc_a(1'b1, 1'b1, 1'b0, 32'hBEEF);
      chk("a_full_wrrd_count", 32'(a_cnt), 32'd15);
      chk("a_full_wrrd_ovf", 32'(a_ovf), 32'd1);
      for (int i = 0; i < 15; i++) cyc_a(1'b0, 1'b1, 1'b0, 32'h0);
      cyc_a(1'b0, 1'b0, 1'b0, 32'h0);
      chk("a_drain_empty", 32'(a_empty), 32'd1);
      chk("a_drain_count", 32'(a_cnt), 32'd0);
      chk("a_rvalid_cycles", 32'(a_rv_cnt), 32'd16);
      chk("a_ovf_sticky", 32'(a_ovf), 32'd1);
      cyc_a(1'b0, 1'b1, 1'b0, 32'h0);
      chk("a_udf_flag", 32'(a_udf), 32'd1);
      chk("a_udf_rvalid", 32'(a_rvalid), 32'd0);

      // ---- A: flush at count 10 together with a write ----
      for (int i = 0; i < 10; i++) cyc_a(1'b1, 1'b0, 1'b0, 32'h100 + 32'(i));
      chk("a_preflush_count", 32'(a_cnt), 32'd10);
      cyc_a(1'b1, 1'b0, 1'b1, 32'hFFFF);
      chk("a_flush_count", 32'(a_cnt), 32'd0);
      chk("a_flush_flags", {26'd0, a_full, a_empty, a_af, a_ae, a_ovf, a_udf}, 32'b010100);
      chk("a_flush_rvalid", 32'(a_rvalid), 32'd0);

      // ---- A: asynchronous reset mid-burst at count 7 ----
      for (int i = 0; i < 7; i++) cyc_a(1'b1, 1'b0, 1'b0, 32'h200 + 32'(i));
      cyc_a(1'b0, 1'b1, 1'b0, 32'h0);
      rst_n = 1'b0;
      #1;
      chk("a_arst_count", 32'(a_cnt), 32'd0);
      chk("a_arst_rvalid", 32'(a_rvalid), 32'd0);
      chk("a_arst_rdata", a_rdata, 32'd0);
      chk("a_arst_flags", {26'd0, a_full, a_empty, a_af, a_ae, a_ovf, a_udf}, 32'b010100);
      a_exp_q.delete();
      a_mcnt = 0;
      #2;
      rst_n = 1'b1;
      cyc_a(1'b1, 1'b0, 1'b0, 32'h77);
      chk("a_post_rst_count", 32'(a_cnt), 32'd1);
      cyc_a(1'b0, 1'b1, 1'b0, 32'h0);
      cyc_a(1'b0, 1'b0, 1'b0, 32'h0);
      chk("a_post_rst_drained", a_exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dma_stream_fifo.md
Name: dma_stream_fifo

Overview:
Parametrised synchronous FIFO for DMA read/write data paths; successor to the fixed 32x16 DMA buffer.
Adds a selectable read mode (registered or first-word fall-through), almost-full/almost-empty watermarks, an occupancy count, synchronous flush, and sticky overflow/underflow flags.
Sits between the DMA bus-master engine and the burst packer/unpacker; one instance per DMA channel direction.

Parameters:
DATA_WIDTH, 32, payload width in bits (>=1)
FIFO_DEPTH, 16, number of entries (>=2, any integer; no power-of-two requirement)
FWFT, 0, 0 = registered read (data one cycle after rd_en); 1 = first-word fall-through
AF_LEVEL, FIFO_DEPTH-2, almost_full asserted when count >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL
CW, $clog2(FIFO_DEPTH+1), count width (derived, not overridable)

Ports:
clk  in  1  clock; the only clock
rst  in  1  reset, asynchronous assert, active-low (one clock; reset is asynchronous and active-low)
flush  in  1  synchronous clear of contents and flags
wr_en  in  1  write request
wdata  in  DATA_WIDTH  write data
rd_en  in  1  read request (FWFT=1: pop of the visible head)
rdata  out  DATA_WIDTH  read data
rvalid  out  1  rdata valid
full  out  1  count == FIFO_DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  CW  current occupancy
overflow  out  1  sticky: wr_en seen while full
underflow  out  1  sticky: rd_en seen while empty

Behaviour:
- wr_acc = wr_en & ~full; rd_acc = rd_en & ~empty. Only accepted operations move pointers or count.
- count next: +1 on wr_acc only; -1 on rd_acc only; unchanged on both or neither. Never exceeds FIFO_DEPTH, never underflows.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap to 0 after FIFO_DEPTH-1. Explicit compare, no natural overflow.
- Full with wr_en & rd_en: the read is accepted, the write is rejected, overflow is set, and count becomes DEPTH-1.
- Empty with wr_en & rd_en: the write is accepted, the read is rejected, underflow is set, and count becomes 1.
- FWFT=0 mode:
  - On rd_acc, rdata <= mem[rd_ptr] and rvalid is 1 the next cycle.
  - rvalid is 0 in any cycle following a non-accepted read.
  - rdata holds its last value.
- FWFT=1 mode:
  - rdata = mem[rd_ptr] combinationally; rvalid = ~empty.
  - A written word is visible the cycle after wr_acc (write-to-read latency 1).
  - rd_acc advances the head.
- Flags (full, empty, almost_full, almost_empty) decode combinationally from the registered count.
- overflow and underflow set on the rejected request. They stay set until flush or reset.
- flush (synchronous) takes priority over wr_en/rd_en in the same cycle; both requests are dropped. It sets:
  - pointers = 0, count = 0, rvalid = 0
  - overflow = 0, underflow = 0
  - storage untouched; rdata holds in FWFT=0.
- Reset (rst low, any time incl. mid-burst) sets:
  - pointers = 0, count = 0, rdata = 0, rvalid = 0, overflow = 0, underflow = 0
  - derived: empty = 1, full = 0, almost_empty = 1, almost_full = 0 (for AF_LEVEL > 0)
  - storage array is not reset.
- Elaboration checks: FIFO_DEPTH >= 2; 0 <= AE_LEVEL < AF_LEVEL <= FIFO_DEPTH; violations are fatal.

Optional Feature:
Macro DMA_FIFO_PARITY_EN.
- Defined:
  - Each entry stores an extra even-parity bit computed from wdata on write.
  - An added output parity_err (1 bit) pulses for one cycle, aligned with rvalid, when the parity check fails on the data presented.
  - FWFT=1: checked on rd_acc. FWFT=0: checked on the registered rdata.
  - Reset/flush value 0.
- Undefined: no extra storage bit and no parity_err port.

Decomposition:
- Package dma_fifo_pkg:
  - read-mode constants FIFO_MODE_REG = 0 and FIFO_MODE_FWFT = 1
  - function fifo_cnt_w(depth) returning $clog2(depth+1)
  - typedef fifo_status_t, a packed struct of full, empty, almost_full, almost_empty, overflow and underflow, so channel arbiters read status as one bus.
- One sub-module is natural: dma_fifo_mem, a plain DATA_WIDTH(+1) x FIFO_DEPTH register array with write port and async read address, so it can later be swapped for an SRAM macro. Control stays in dma_stream_fifo.

Test Plan:
- DEPTH=16, FWFT=0: write 0x00000001..0x00000010, then read 16 -> rdata appears one cycle after each rd_en in order; full=1 at count 16; empty=1 after the last read; rvalid=1 for exactly 16 cycles.
- DEPTH=5 (non-power-of-two): 3 write/read rounds of 4 words each -> pointers wrap 4->0; data order preserved; count never exceeds 5.
- Full FIFO, one more wr_en with no read -> count stays 16, overflow=1 sticky; next read returns the original head, not the dropped word. Full FIFO with wr_en & rd_en -> count 15, overflow=1.
- FWFT=1: write 0xA5A5A5A5 into an empty FIFO -> next cycle rvalid=1, rdata=0xA5A5A5A5 without rd_en. rd_en on empty with wr_en -> count 1, underflow=1.
- AF_LEVEL=14, AE_LEVEL=2: fill sequentially -> almost_empty deasserts at count 3 and almost_full asserts at count 14. Flush at count 10 together with wr_en -> next cycle count 0, empty=1, flags and sticky bits 0, write dropped.
- Assert rst low mid-burst at count 7 -> outputs take reset values immediately (async); after release, the FIFO accepts writes on the first clk edge.
